// File: rtl/highway_road_controller.sv
// -----------------------------------------------------------------------------
// highway_road_controller
//
// Highway side of the highway / country-road traffic light pair. It waits in
// RED until the country controller hands over with enable_h, holds green for a
// minimum number of tick pulses, then stays green until a country-road car has
// been seen. It then runs a timed yellow and returns control with a one-cycle
// enable_c pulse on the first red cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   tick         timebase enable for the phase counter
//   car_c        country-road vehicle sensor (level)
//   enable_h     one-cycle pulse: country is red, highway may go green
//   enable_c     one-cycle pulse: highway is red, country may go green
//   light_h      highway lamp, one-hot: 001 red, 010 yellow, 100 green
//   protocol_err sticky flag: enable_h arrived while the highway was not red
// -----------------------------------------------------------------------------
module highway_road_controller #(
  parameter int MIN_GREEN   = 25,
  parameter int YELLOW_TIME = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_c,
  input  logic       enable_h,
  output logic       enable_c,
  output logic [2:0] light_h,
  output logic       protocol_err
);

  typedef enum logic [1:0] {
    RED        = 2'd0,
    GREEN_MIN  = 2'd1,
    GREEN_HOLD = 2'd2,
    YELLOW     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             car_req;
  logic             min_done;
  logic             yellow_done;
  logic             in_green;

  assign min_done    = tick && (cnt == MIN_LAST);
  assign yellow_done = tick && (cnt == YELLOW_LAST);
  assign in_green    = (state == GREEN_MIN) || (state == GREEN_HOLD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; car_c is deliberately ignored while red
  always_comb begin
    state_nxt = state;
    case (state)
      RED:        if (enable_h)          state_nxt = GREEN_MIN;
      GREEN_MIN:  if (min_done)          state_nxt = GREEN_HOLD;
      GREEN_HOLD: if (car_req || car_c)  state_nxt = YELLOW;
      YELLOW:     if (yellow_done)       state_nxt = RED;
      default:                           state_nxt = RED;
    endcase
  end

  // Phase counter, car latch, handshake and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      car_req      <= 1'b0;
      enable_c     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      // Every state change restarts the phase count; the terminal compare
      // ends the phase before the counter could wrap.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (tick && ((state == GREEN_MIN) || (state == YELLOW))) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Clearing on yellow entry takes precedence over a car seen that cycle.
      if ((state == GREEN_HOLD) && (state_nxt == YELLOW)) begin
        car_req <= 1'b0;
      end else if (in_green && car_c) begin
        car_req <= 1'b1;
      end

      enable_c <= (state == YELLOW) && yellow_done;

      // A stray enable_h is only flagged; it does not disturb the phase.
      if (enable_h && (state != RED)) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Moore lamp decode
  always_comb begin
    light_h = 3'b001;
    case (state)
      RED:        light_h = 3'b001;
      GREEN_MIN:  light_h = 3'b100;
      GREEN_HOLD: light_h = 3'b100;
      YELLOW:     light_h = 3'b010;
      default:    light_h = 3'b001;
    endcase
  end

endmodule

// File: doc/highway_road_controller.md
Name: highway_road_controller

Overview:
- Highway-side controller of the highway / country-road traffic light pair.
- It is the peer of the country-road controller and closes the handshake loop: it receives enable_h when the country road has gone red, and it returns enable_c when the highway has gone red.
- It contains its own tick-driven phase timer, a sticky car-request latch fed by the country-road sensor, and a protocol-error flag.

Parameters:
- MIN_GREEN, 25: minimum highway green duration, in tick pulses (1 to 2^CNT_W-1).
- YELLOW_TIME, 4: highway yellow duration, in tick pulses (1 to 2^CNT_W-1).
- CNT_W, 8: phase counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  timebase enable; the counter advances only on cycles where tick=1.
- car_c  in  1  country-road vehicle sensor, level; may be high on any cycle.
- enable_h  in  1  one-cycle pulse from the country controller: country is red, highway may go green.
- enable_c  out  1  one-cycle pulse to the country controller: highway is red, country may go green.
- light_h  out  3  highway lamp, one-hot: 001 red, 010 yellow, 100 green.
- protocol_err  out  1  sticky; set when enable_h arrives while the highway is not red.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all inputs and takes effect in any state, including mid-phase. After reset:
  - state=RED, light_h=001
  - enable_c=0, protocol_err=0
  - counter=0, car_req=0
- The highway resets to RED so that it never comes up green alongside the country road.
- Moore outputs: light_h is decoded from the state register and changes on the clock edge after the causing input.
- States and transitions:
  - RED: stay until enable_h=1, then go to GREEN_MIN with counter cleared. car_c is ignored here.
  - GREEN_MIN: if tick=1, counter+1. On a cycle with tick=1 and counter==MIN_GREEN-1, go to GREEN_HOLD with counter cleared. This gives exactly MIN_GREEN ticks of green.
  - GREEN_HOLD: if car_req=1 or car_c=1, go to YELLOW with counter cleared. Otherwise stay green indefinitely.
  - YELLOW: if tick=1, counter+1. On a cycle with tick=1 and counter==YELLOW_TIME-1, go to RED. In that same edge, enable_c is registered to 1.
- light_h per state: GREEN_MIN and GREEN_HOLD → 100, YELLOW → 010, RED → 001.
- enable_c:
  - High for exactly one clk: the first cycle in which light_h=001 after a YELLOW phase.
  - 0 on every other cycle.
  - Never asserted after reset alone.
- car_req:
  - Set when car_c=1 in GREEN_MIN or GREEN_HOLD.
  - Cleared on entry to YELLOW.
  - A car seen during the minimum green is remembered, so GREEN_HOLD lasts exactly one cycle when car_req is already set.
- Counter:
  - CNT_W bits; never wraps, because the compare terminates the phase first.
  - Holds its value on tick=0 cycles.
  - Cleared on every state change.
- protocol_err:
  - Set when enable_h=1 in GREEN_MIN, GREEN_HOLD or YELLOW.
  - The stray pulse is otherwise ignored: state, counter and car_req are unaffected.
  - Cleared only by rst.
- Simultaneous events:
  - enable_h=1 on the same cycle as enable_c=1 (first RED cycle): accepted; go to GREEN_MIN next edge.
  - car_c=1 on the last GREEN_MIN tick: latched into car_req, so GREEN_HOLD lasts one cycle.
  - tick=1 and rst=1 together: rst wins.
- Safety invariants (assert in the bench):
  - light_h is always one-hot.
  - Green is only entered from RED via enable_h.
  - YELLOW always precedes RED except on reset.

Test Plan:
- Reset/idle: MIN_GREEN=3, YELLOW_TIME=2, rst for 2 clk, no enable_h for 20 clk → light_h=001, enable_c=0, protocol_err=0 throughout.
- Full cycle: enable_h pulse, tick every cycle, car_c=1 held → green exactly 3 ticks plus 1 HOLD cycle, yellow exactly 2 ticks, then light_h=001 with enable_c=1 for one clk only.
- No car / latched car: no car_c for 50 ticks → light_h stays 100. Then a one-cycle car_c pulse during GREEN_MIN → yellow entered one cycle after MIN_GREEN expires.
- Sparse tick: tick every 4th cycle → green lasts 12 clk, yellow lasts 8 clk; the counter holds on gap cycles.
- Protocol error: enable_h pulse during YELLOW → protocol_err=1 next edge; the yellow timing is unchanged; the flag persists until rst.
- Mid-phase reset: rst asserted in the 2nd yellow tick → next edge light_h=001, enable_c=0, counter=0. A later enable_h restarts a full MIN_GREEN.
